// File: rtl/lac_serial_adder.sv
// lac_serial_adder: multi-cycle wide adder built around one 16-bit lookahead-carry unit.
// Also holds lac_unit, the purely combinational 16-bit two-level carry-lookahead adder
// that it drives.
//
// Operands of WIDTH = 16*SLICES bits are latched on an accepted start. One 16-bit slice
// is added per clock, least significant first. Each slice's carry out is registered and
// used as the carry in of the next slice.
//
// Optional feature macro: LAC_SUB_EN
//   defined   -> adds input 'sub'. With sub=1 the result is a - b: B is inverted and the
//                slice-0 carry is forced to 1, so cin is ignored. cout=1 means no borrow.
//   undefined -> pure adder, sum = a + b + cin.
//
// Ports (lac_serial_adder):
//   clk    in  1      rising-edge clock
//   rst_n  in  1      asynchronous active-low reset
//   start  in  1      request, sampled only while busy == 0
//   a, b   in  WIDTH  operands, latched on an accepted start
//   cin    in  1      carry into slice 0, latched on an accepted start
//   sub    in  1      subtract select (LAC_SUB_EN only), latched on an accepted start
//   busy   out 1      high while slices are being processed
//   done   out 1      one-cycle pulse when sum/cout/ovf become valid
//   sum    out WIDTH  result, held until the next accepted start
//   cout   out 1      carry out of the top slice
//   ovf    out 1      two's-complement overflow of the full-width operation
//
// Ports (lac_unit):
//   a_i, b_i  in  16  slice operands
//   cin_i     in  1   carry in
//   s_o       out 16  slice sum
//   cout_o    out 1   carry out
//   p_o, g_o  out 1   block propagate / generate

module lac_unit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] s_o,
  output logic        cout_o,
  output logic        p_o,
  output logic        g_o
);

  // 4-bit lookahead: returns carries c1..c4 in bits [0..3] for carry-in c0.
  // Used both inside each nibble and across the four nibble groups.
  function automatic logic [3:0] cla4(input logic [3:0] p, input logic [3:0] g,
                                      input logic c0);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & c0);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  logic [15:0] p_bit;
  logic [15:0] g_bit;
  logic [3:0]  grp_p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_c;      // carry out of each nibble group
  logic [3:0]  grp_cin;    // carry into each nibble group
  logic [15:0] bit_cin;    // carry into each bit
  logic [3:0]  blk_g_vec;

  assign p_bit = a_i ^ b_i;
  assign g_bit = a_i & b_i;

  always_comb begin
    logic [3:0] tmp;
    grp_p = '0;
    grp_g = '0;
    for (int j = 0; j < 4; j++) begin
      tmp      = cla4(p_bit[4*j +: 4], g_bit[4*j +: 4], 1'b0);
      grp_g[j] = tmp[3];
      grp_p[j] = &p_bit[4*j +: 4];
    end
  end

  assign grp_c     = cla4(grp_p, grp_g, cin_i);
  assign grp_cin   = {grp_c[2:0], cin_i};
  assign blk_g_vec = cla4(grp_p, grp_g, 1'b0);

  always_comb begin
    logic [3:0] tmp;
    bit_cin = '0;
    for (int j = 0; j < 4; j++) begin
      tmp                  = cla4(p_bit[4*j +: 4], g_bit[4*j +: 4], grp_cin[j]);
      bit_cin[4*j]         = grp_cin[j];
      bit_cin[4*j+1 +: 3]  = tmp[2:0];
    end
  end

  assign s_o    = p_bit ^ bit_cin;
  assign cout_o = grp_c[3];
  assign p_o    = &grp_p;
  assign g_o    = blk_g_vec[3];

endmodule

module lac_serial_adder #(
  parameter int unsigned SLICES = 4,
  localparam int unsigned WIDTH = 16 * SLICES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef LAC_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Operand registers shift right one slice per cycle, so the active slice is always [15:0]
  // and on the last slice bit 15 is the full-width MSB.
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              inv_b;

  logic [15:0]       lac_a;
  logic [15:0]       lac_b;
  logic [15:0]       lac_s;
  logic              lac_cout;
  logic              last_slice;

`ifdef LAC_SUB_EN
  logic sub_q, sub_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else begin
      sub_q <= sub_d;
    end
  end

  always_comb begin
    sub_d = sub_q;
    if (state_q == StIdle && start) begin
      sub_d = sub;
    end
  end

  assign inv_b = sub_q;
`else
  assign inv_b = 1'b0;
`endif

  assign lac_a      = a_q[15:0];
  assign lac_b      = b_q[15:0] ^ {16{inv_b}};
  assign last_slice = (cnt_q == CntW'(SLICES - 1));

  // Block P/G are not needed for a serial ripple of slices.
  lac_unit u_lac (
    .a_i    (lac_a),
    .b_i    (lac_b),
    .cin_i  (carry_q),
    .s_o    (lac_s),
    .cout_o (lac_cout),
    .p_o    (),
    .g_o    ()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
`ifdef LAC_SUB_EN
          carry_d = sub ? 1'b1 : cin;
`else
          carry_d = cin;
`endif
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned k = 0; k < SLICES; k++) begin
          if (cnt_q == CntW'(k)) begin
            sum_d[16*k +: 16] = lac_s;
          end
        end
        carry_d = lac_cout;
        a_d     = a_q >> 16;
        b_d     = b_q >> 16;
        cnt_d   = cnt_q + 1'b1;
        if (last_slice) begin
          cout_d  = lac_cout;
          ovf_d   = (lac_a[15] == lac_b[15]) && (lac_s[15] != lac_a[15]);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q == StRun);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_lac_serial_adder.sv
// Self-checking bench for lac_serial_adder (SLICES=4, WIDTH=64): directed vector table,
// hand-written multi-cycle sequences, and a randomized sweep against a plain-arithmetic
// reference model.
module tb_lac_serial_adder;

  localparam int unsigned SLICES = 4;
  localparam int unsigned WIDTH  = 64;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             cin   = 1'b0;
  logic             sub   = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lac_serial_adder #(.SLICES(SLICES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef LAC_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: whole-width arithmetic, no slicing.
  task automatic model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic cv, input logic sv, output logic [WIDTH-1:0] es,
                       output logic ec, output logic eo);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] be;
    be   = sv ? ~bv : bv;
    full = {1'b0, av} + {1'b0, be} + (WIDTH+1)'(sv ? 1'b1 : cv);
    es   = full[WIDTH-1:0];
    ec   = full[WIDTH];
    eo   = (av[WIDTH-1] == be[WIDTH-1]) && (es[WIDTH-1] != av[WIDTH-1]);
  endtask

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic cv, input logic sv);
    a     = av;
    b     = bv;
    cin   = cv;
    sub   = sv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", WIDTH'(busy), WIDTH'(1));
  endtask

  // Bounded wait for done, sampled at negedges.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 50);
    chk("done_seen", WIDTH'(done), WIDTH'(1));
  endtask

  task automatic run_and_check(input string name, input logic [WIDTH-1:0] av,
                               input logic [WIDTH-1:0] bv, input logic cv, input logic sv,
                               input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int lat;
    launch(av, bv, cv, sv);
    wait_done(lat);
    chk({name, "_latency"}, WIDTH'(lat), WIDTH'(SLICES));
    chk({name, "_busy_low"}, WIDTH'(busy), '0);
    chk({name, "_sum"}, sum, es);
    chk({name, "_cout"}, WIDTH'(cout), WIDTH'(ec));
    chk({name, "_ovf"}, WIDTH'(ovf), WIDTH'(eo));
    @(negedge clk);
    chk({name, "_done_one_cycle"}, WIDTH'(done), '0);
    chk({name, "_sum_held"}, sum, es);
  endtask

  initial begin
    vec_t             vecs[$];
    logic [WIDTH-1:0] es;
    logic             ec;
    logic             eo;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic             rs;
    int               lat;
    int               seen;

    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0});
    vecs.push_back('{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
                     64'h0001_0000_0001_0000, 1'b0, 1'b0});
    vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                     64'h8000_0000_0000_0000, 1'b0, 1'b1});
    vecs.push_back('{64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                     64'h0, 1'b1, 1'b1});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 1'b0, 64'h1_0000, 1'b0, 1'b0});
`ifdef LAC_SUB_EN
    vecs.push_back('{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
    vecs.push_back('{64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0});
`endif

    // Reset state, with start held high to show it is ignored under reset.
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", WIDTH'(busy), '0);
    chk("rst_done", WIDTH'(done), '0);
    chk("rst_sum", sum, '0);
    chk("rst_cout", WIDTH'(cout), '0);
    chk("rst_ovf", WIDTH'(ovf), '0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                    vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
    end

    // start and operand changes while busy are ignored.
    launch(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    @(negedge clk);
    a     = 64'hDEAD_BEEF_DEAD_BEEF;
    b     = 64'hFFFF_0000_FFFF_0000;
    cin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("busy_ignore_sum", sum, 64'h2222_2222_2222_2211);
    chk("busy_ignore_cout", WIDTH'(cout), '0);
    @(negedge clk);
    chk("busy_ignore_no_restart", WIDTH'(busy), '0);

    // Back-to-back: start raised in the done cycle is accepted at the next edge.
    launch(64'h1, 64'h2, 1'b0, 1'b0);
    wait_done(lat);
    launch(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
    chk("b2b_done_cleared", WIDTH'(done), '0);
    wait_done(lat);
    chk("b2b_latency", WIDTH'(lat), WIDTH'(SLICES));
    chk("b2b_sum", sum, 64'h0);
    chk("b2b_cout", WIDTH'(cout), WIDTH'(1));

    // Reset mid-operation aborts with no done and a cleared sum.
    @(negedge clk);
    launch(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", WIDTH'(busy), '0);
    chk("midrst_done", WIDTH'(done), '0);
    chk("midrst_sum", sum, '0);
    chk("midrst_cout", WIDTH'(cout), '0);
    chk("midrst_ovf", WIDTH'(ovf), '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("midrst_no_done", WIDTH'(seen), '0);
    chk("midrst_sum_after", sum, '0);

    // Randomized sweep against the reference model.
    for (int i = 0; i < 200; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 8 == 0) rb = ~ra;
      rc = 1'($urandom);
`ifdef LAC_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      model(ra, rb, rc, rs, es, ec, eo);
      run_and_check($sformatf("rnd%0d", i), ra, rb, rc, rs, es, ec, eo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
